// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for two requesters that share a 2:1 data mux.
// A grant lasts up to MAX_BURST beats. The selected beat goes into a
// single-entry output register with a valid/ready handshake.
module rr_mux_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_req0_valid,
    input  logic [DATA_W-1:0]                i_req0_data,
    output logic                             o_req0_ready,
    input  logic                             i_req1_valid,
    input  logic [DATA_W-1:0]                i_req1_data,
    output logic                             o_req1_ready,
    output logic                             o_out_valid,
    output logic [DATA_W-1:0]                o_out_data,
    input  logic                             i_out_ready,
    output logic                             o_sel,
    output logic                             o_busy,
    output logic [$clog2(MAX_BURST+1)-1:0]   o_beat_cnt
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_t;

    state_t              r_state;
    logic                r_last;
    logic                r_sel;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [CNT_W-1:0]    r_beat_cnt;

    logic                w_slot_free;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_granted;
    logic                w_cur;
    logic                w_cur_valid;
    logic [DATA_W-1:0]   w_cur_data;
    logic                w_accept;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_exit;
    logic [1:0]          w_arb_last;
    logic [1:0]          w_arb_cur;

    // Returns {found, pick}: the requester other than l wins a tie.
    function automatic logic [1:0] arb(input logic l, input logic v0, input logic v1);
        logic other_v;
        logic self_v;
        other_v = l ? v0 : v1;
        self_v  = l ? v1 : v0;
        if (other_v) begin
            return {1'b1, ~l};
        end else if (self_v) begin
            return {1'b1, l};
        end
        return 2'b00;
    endfunction

    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_gnt0      = (r_state == StGrant0);
    assign w_gnt1      = (r_state == StGrant1);
    assign w_granted   = w_gnt0 || w_gnt1;
    assign w_cur       = w_gnt1;
    assign w_cur_valid = w_gnt1 ? i_req1_valid : (w_gnt0 && i_req0_valid);
    assign w_cur_data  = w_gnt1 ? i_req1_data : i_req0_data;

    // Readies are gated by reset so a beat offered during reset is never taken.
    assign o_req0_ready = w_gnt0 && w_slot_free && !i_rst;
    assign o_req1_ready = w_gnt1 && w_slot_free && !i_rst;

    assign w_accept   = w_granted && w_cur_valid && w_slot_free && !i_rst;
    assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);
    assign w_exit     = w_granted &&
                        ((w_accept && (w_cnt_inc == CNT_W'(MAX_BURST))) || !w_cur_valid);
    assign w_arb_last = arb(r_last, i_req0_valid, i_req1_valid);
    assign w_arb_cur  = arb(w_cur, i_req0_valid, i_req1_valid);

    // Grant FSM, burst counter and output register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_last      <= 1'b1;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_beat_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= w_cur_data;
                r_out_valid <= 1'b1;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_arb_last[1]) begin
                        r_state <= w_arb_last[0] ? StGrant1 : StGrant0;
                        r_sel   <= w_arb_last[0];
                    end
                end
                StGrant0, StGrant1: begin
                    if (w_exit) begin
                        r_last     <= w_cur;
                        r_beat_cnt <= '0;
                        if (w_arb_cur[1]) begin
                            r_state <= w_arb_cur[0] ? StGrant1 : StGrant0;
                            r_sel   <= w_arb_cur[0];
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_accept) begin
                        r_beat_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_sel       = r_sel;
    assign o_busy      = (r_state != StIdle);
    assign o_beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: directed scenarios plus a random phase, checked
// against a cycle-level reference model and an in-order data scoreboard.
module tb_rr_mux_arbiter;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1);

    logic                clk;
    logic                i_rst;
    logic                i_req0_valid;
    logic [DATA_W-1:0]   i_req0_data;
    logic                o_req0_ready;
    logic                i_req1_valid;
    logic [DATA_W-1:0]   i_req1_data;
    logic                o_req1_ready;
    logic                o_out_valid;
    logic [DATA_W-1:0]   o_out_data;
    logic                i_out_ready;
    logic                o_sel;
    logic                o_busy;
    logic [CNT_W-1:0]    o_beat_cnt;

    rr_mux_arbiter #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_req0_valid (i_req0_valid),
        .i_req0_data  (i_req0_data),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_data  (i_req1_data),
        .o_req1_ready (o_req1_ready),
        .o_out_valid  (o_out_valid),
        .o_out_data   (o_out_data),
        .i_out_ready  (i_out_ready),
        .o_sel        (o_sel),
        .o_busy       (o_busy),
        .o_beat_cnt   (o_beat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard of beats the model says were accepted, in order.
    logic [DATA_W-1:0] exp_q[$];

    // Reference model: who owns the channel, beats taken in this burst,
    // previous owner, expected sel, and whether the output slot is full.
    int m_owner = -1;
    int m_taken = 0;
    int m_last  = 1;
    int m_sel   = 0;
    int m_full  = 0;

    always @(negedge clk) begin
        int v[2];
        logic [DATA_W-1:0] d[2];
        int slot;
        int pref;
        v[0] = int'(i_req0_valid);
        v[1] = int'(i_req1_valid);
        d[0] = i_req0_data;
        d[1] = i_req1_data;
        if (i_rst) begin
            chk("rst_ready0", int'(o_req0_ready), 0);
            chk("rst_ready1", int'(o_req1_ready), 0);
            m_owner = -1;
            m_taken = 0;
            m_last  = 1;
            m_sel   = 0;
            m_full  = 0;
            exp_q.delete();
        end else begin
            chk("busy", int'(o_busy), (m_owner >= 0) ? 1 : 0);
            chk("sel", int'(o_sel), m_sel);
            chk("beat_cnt", int'(o_beat_cnt), m_taken);
            chk("out_valid", int'(o_out_valid), m_full);
            slot = (m_full == 0 || i_out_ready) ? 1 : 0;
            chk("ready0", int'(o_req0_ready), (m_owner == 0 && slot == 1) ? 1 : 0);
            chk("ready1", int'(o_req1_ready), (m_owner == 1 && slot == 1) ? 1 : 0);
            if (m_owner >= 0 && slot == 1 && v[m_owner] == 1) begin
                exp_q.push_back(d[m_owner]);
                m_taken++;
                m_full = 1;
            end else if (slot == 1) begin
                m_full = 0;
            end
            if (m_owner < 0 || v[m_owner] == 0 || m_taken == MAX_BURST) begin
                if (m_owner >= 0) m_last = m_owner;
                pref = 1 - m_last;
                if (v[pref] == 1) m_owner = pref;
                else if (v[m_last] == 1) m_owner = m_last;
                else m_owner = -1;
                m_taken = 0;
                if (m_owner >= 0) m_sel = m_owner;
            end
        end
    end

    // Output monitor: every downstream transfer must match the next expected beat.
    always @(negedge clk) begin
        if (!i_rst && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_extra: got beat %0d expected no beat at %0t",
                         o_out_data, $time);
            end else begin
                chk("out_data", int'(o_out_data), int'(exp_q.pop_front()));
            end
        end
    end

    bit                rand_mode = 0;
    bit                s_acc0;
    bit                s_acc1;
    logic [DATA_W-1:0] s_out_data;
    int                s_out_valid;
    int                s_sel;
    int                s_busy;
    int                s_cnt;

    // One clock: snapshot at the falling edge, then advance past the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_acc0      = i_req0_valid && o_req0_ready;
        s_acc1      = i_req1_valid && o_req1_ready;
        s_out_data  = o_out_data;
        s_out_valid = int'(o_out_valid);
        s_sel       = int'(o_sel);
        s_busy      = int'(o_busy);
        s_cnt       = int'(o_beat_cnt);
        @(posedge clk);
        #1;
        if (rand_mode) begin
            i_req0_data = DATA_W'($urandom);
            i_req1_data = DATA_W'($urandom);
        end else begin
            if (s_acc0) i_req0_data = i_req0_data + 1'b1;
            if (s_acc1) i_req1_data = i_req1_data + 1'b1;
        end
    endtask

    initial begin
        int n_acc;
        logic [DATA_W-1:0] held;

        i_rst        = 1'b1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        i_req0_data  = 8'h11;
        i_req1_data  = 8'h22;
        i_out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;

        // Reset values, then the first tie goes to requester 0.
        cycle();
        chk("rst_out_data", int'(s_out_data), 0);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_sel", s_sel, 0);
        chk("rst_busy", s_busy, 0);
        cycle();
        chk("first_grant_busy", s_busy, 1);
        chk("first_grant_sel", s_sel, 0);
        chk("first_grant_acc0", int'(s_acc0), 1);
        repeat (4) cycle();
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        repeat (4) cycle();

        // Single requester: three beats, accepted in cycles 1..3.
        i_req0_data  = 8'hA1;
        i_req0_valid = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (s_acc0) n_acc++;
        end
        i_req0_valid = 1'b0;
        chk("single_accepts", n_acc, 3);
        cycle();
        chk("single_out_a3", int'(s_out_data), 8'hA3);
        repeat (3) cycle();
        chk("single_idle", s_busy, 0);

        // Contention with a 3-cycle backpressure window mid-burst.
        i_req0_data  = 8'h10;
        i_req1_data  = 8'h90;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        held = '0;
        for (int i = 0; i < 26; i++) begin
            i_out_ready = !(i >= 10 && i < 13);
            cycle();
            if (i == 10) held = s_out_data;
            if (i == 11 || i == 12) chk("bp_hold", int'(s_out_data), int'(held));
        end
        i_out_ready = 1'b1;

        // Solo re-grant of requester 1.
        i_req0_valid = 1'b0;
        for (int i = 0; i < 12; i++) cycle();
        i_req1_valid = 1'b0;
        repeat (3) cycle();

        // Reset while the output holds a beat and beat_cnt is 2.
        i_req0_valid = 1'b1;
        repeat (3) cycle();
        i_rst = 1'b1;
        cycle();
        chk("pre_rst_cnt", s_cnt, 2);
        chk("pre_rst_valid", s_out_valid, 1);
        i_rst = 1'b0;
        cycle();
        chk("post_rst_valid", s_out_valid, 0);
        chk("post_rst_busy", s_busy, 0);
        chk("post_rst_cnt", s_cnt, 0);

        // Random traffic with occasional reset.
        rand_mode = 1;
        for (int i = 0; i < 600; i++) begin
            i_req0_valid = ($urandom_range(0, 3) != 0);
            i_req1_valid = ($urandom_range(0, 3) != 0);
            i_out_ready  = ($urandom_range(0, 3) != 0);
            i_rst        = ($urandom_range(0, 149) == 0);
            cycle();
        end
        i_rst        = 1'b0;
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        i_out_ready  = 1'b1;
        repeat (5) cycle();
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin controller for a shared 2-to-1 data multiplexer. Two requesters contend for one output channel. The block grants one at a time in bursts of up to MAX_BURST beats, drives the mux select, and registers the selected beat into a single-entry output stage with a valid/ready handshake. It sits in front of any downstream consumer that both sources share.

## Interface
- DATA_W, 8, width of each data beat
- MAX_BURST, 4, maximum beats accepted per grant (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a beat
- req0_data  input  DATA_W  requester 0 beat
- req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid
- req1_valid  input  1  requester 1 has a beat
- req1_data  input  DATA_W  requester 1 beat
- req1_ready  output  1  requester 1 beat accepted this cycle when high with req1_valid
- out_valid  output  1  output register holds a beat
- out_data  output  DATA_W  output beat
- out_ready  input  1  downstream accepts out_data this cycle
- sel  output  1  mux select; current/last granted requester
- busy  output  1  high when state ≠ IDLE
- beat_cnt  output  $clog2(MAX_BURST+1)  beats accepted in the current grant

## Operation
- States: IDLE, GRANT0, GRANT1. Internal pointer `last` records the last granted requester.
- arb(L): if the requester other than L is valid, pick it. Else if L is valid, pick L. Else IDLE.
- IDLE: next state = GRANTn per arb(last). No readies asserted in IDLE.
- Slot free = !out_valid || out_ready.
- In GRANTn: reqn_ready = slot free (combinational). The other requester's ready = 0.
- Accept = reqn_valid && reqn_ready. On accept:
  - out_data <= reqn_data;
  - out_valid <= 1;
  - beat_cnt increments.
- If slot free and no accept, out_valid <= 0.
- If !slot free, out_valid and out_data hold unchanged.
- Grant exit in GRANTn occurs when either:
  - (a) an accept brings the beat count to MAX_BURST, or
  - (b) reqn_valid == 0.
- On exit:
  - last <= n;
  - next state = arb(n);
  - beat_cnt <= 0.
- Re-granting the same requester (other idle) starts a fresh burst with no idle cycle.
- Direct GRANT0↔GRANT1 switch has no idle cycle.
- sel: registered. It takes n when entering GRANTn and holds its value in IDLE.
- Data is never dropped or duplicated: every accept produces exactly one out_valid && out_ready transfer, in order.

## Timing
- Reset values:
  - state IDLE;
  - last = 1 (requester 0 wins the first tie);
  - sel = 0, out_valid = 0, out_data = 0;
  - beat_cnt = 0, busy = 0;
  - req0_ready = req1_ready = 0.
- Reset mid-operation discards any beat in the output register. A requester beat presented in the reset cycle is not accepted.
- Latency from IDLE: reqn_valid rises in cycle 0 → state GRANTn and readyn in cycle 1 → out_valid in cycle 2.
- Sustained throughput: 1 beat/cycle with out_ready = 1, including across burst boundaries and grant switches.
- Exit by condition (b) costs the dropped cycle only: the grant moves at the next edge.
- Simultaneous first requests after reset go to requester 0. Thereafter ties go to the requester other than `last`.
- Backpressure: while out_valid && !out_ready, both readies = 0 and out_data is stable.
- beat_cnt is 0 at every grant entry. Its range is 0..MAX_BURST-1 as observed in GRANT states.

## Test plan
- Reset: hold rst 2 cycles with both valids high → all outputs at reset values. First grant after release is GRANT0, sel = 0.
- Single requester: req0 sends 0xA1, 0xA2, 0xA3 with out_ready = 1.
  - Beats appear on out_data in cycles 2, 3, 4.
  - busy drops after req0_valid falls.
  - req1_ready stays 0 throughout.
- Contention, MAX_BURST = 4, both continuously valid, out_ready = 1:
  - out_data shows four req0 beats, then four req1 beats, alternating.
  - sel toggles every 4 beats.
  - No cycle has out_valid = 0 after the first.
- Backpressure: out_ready = 0 for 3 cycles mid-burst.
  - out_data is held constant.
  - Granted ready is 0.
  - After release, the sequence resumes with no lost or repeated beat.
- Solo re-grant: only req1 valid for 10 beats.
  - beat_cnt cycles 0..3.
  - sel stays 1.
  - Continuous 1 beat/cycle output.
- Reset mid-burst: assert rst while out_valid = 1 and beat_cnt = 2 → next cycle out_valid = 0, state IDLE, beat_cnt = 0.
